// File: rtl/sram_bus_bridge.sv
// Bridges the core's inst/data SRAM-style ports onto a single request/response bus
// with one transaction outstanding, stalling the core until every enabled port is served.
module sram_bus_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_stall,
    input  logic              inst_sram_en,
    input  logic [3:0]        inst_sram_wen,
    input  logic [ADDR_W-1:0] inst_sram_addr,
    input  logic [DATA_W-1:0] inst_sram_wdata,
    output logic [DATA_W-1:0] inst_sram_rdata,
    input  logic              data_sram_en,
    input  logic [3:0]        data_sram_wen,
    input  logic [ADDR_W-1:0] data_sram_addr,
    input  logic [DATA_W-1:0] data_sram_wdata,
    output logic [DATA_W-1:0] data_sram_rdata,
    output logic              stallreq_bus,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [3:0]        bus_wstrb,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic [2:0]        dbg_state
);

    // Bus handshake: a request is presented while bus_req=1 and its fields are held
    // until the cycle bus_addr_ok=1; the response (read data or write ack) arrives in
    // a cycle with bus_data_ok=1, at the earliest in the same cycle as bus_addr_ok.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        D_REQ  = 3'd1,
        D_RESP = 3'd2,
        I_REQ  = 3'd3,
        I_RESP = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic inst_done, data_done;
    logic inst_pend, data_pend;
    logic issue_data, issue_inst, addr_acc, finish;
    logic serving_data;
    logic unused_inputs;

    // Fetch is read-only, so its write-side inputs carry no meaning here.
    assign unused_inputs = ^{inst_sram_wen, inst_sram_wdata};

    assign inst_pend    = inst_sram_en & ~inst_done;
    assign data_pend    = data_sram_en & ~data_done;
    assign stallreq_bus = ~rst & (inst_pend | data_pend | (state != IDLE));
    assign serving_data = (state == D_REQ) || (state == D_RESP);
    assign dbg_state    = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        issue_data = 1'b0;
        issue_inst = 1'b0;
        addr_acc   = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (data_pend) begin
                    issue_data = 1'b1;
                    state_nxt  = D_REQ;
                end else if (inst_pend) begin
                    issue_inst = 1'b1;
                    state_nxt  = I_REQ;
                end
            end
            D_REQ, I_REQ: begin
                if (bus_addr_ok) begin
                    addr_acc = 1'b1;
                    if (bus_data_ok) begin
                        finish    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = (state == D_REQ) ? D_RESP : I_RESP;
                    end
                end
            end
            D_RESP, I_RESP: begin
                if (bus_data_ok) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_req         <= 1'b0;
            bus_wr          <= 1'b0;
            bus_wstrb       <= '0;
            bus_addr        <= '0;
            bus_wdata       <= '0;
            inst_sram_rdata <= '0;
            data_sram_rdata <= '0;
            inst_done       <= 1'b0;
            data_done       <= 1'b0;
        end else begin
            if (issue_data) begin
                bus_req   <= 1'b1;
                bus_wr    <= |data_sram_wen;
                bus_wstrb <= data_sram_wen;
                bus_addr  <= data_sram_addr;
                bus_wdata <= data_sram_wdata;
            end else if (issue_inst) begin
                bus_req   <= 1'b1;
                bus_wr    <= 1'b0;
                bus_wstrb <= '0;
                bus_addr  <= inst_sram_addr;
                bus_wdata <= '0;
            end else if (addr_acc) begin
                bus_req <= 1'b0;
            end

            // Done flags survive until the core actually moves past the access,
            // so a store held on the port is never issued twice.
            if (finish) begin
                if (serving_data) begin
                    if (!bus_wr) begin
                        data_sram_rdata <= bus_rdata;
                    end
                    data_done <= 1'b1;
                end else begin
                    inst_sram_rdata <= bus_rdata;
                    inst_done       <= 1'b1;
                end
            end else if (!stallreq_bus && !core_stall) begin
                inst_done <= 1'b0;
                data_done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sram_bus_bridge.sv
// Self-checking bench for sram_bus_bridge: randomized accesses against a behavioural
// slave and a reference memory/latency model, plus directed reset and hold scenarios.
module tb_sram_bus_bridge;

    localparam int TXN_W = 69;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } txn_t;

    logic        clk;
    logic        rst;
    logic        core_stall;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        stallreq_bus;
    logic        bus_req;
    logic        bus_wr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok = 1'b0;
    logic        bus_data_ok = 1'b0;
    logic [31:0] bus_rdata   = 32'h0;
    logic [2:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    // slave configuration, written by the stimulus process only
    int          aw = 0;
    int          dw = 0;
    bit          sl_comb = 1'b0;
    bit          spurious = 1'b0;
    bit          man_mode = 1'b0;
    bit          man_addr_ok = 1'b0;
    bit          man_data_ok = 1'b0;
    logic [31:0] man_rdata = 32'h0;

    // slave-owned state
    int          sl_phase = 0;
    int          sl_cnt = 0;
    bit          req_seen = 1'b0;
    txn_t        req_snap;
    int          req_cycles = 0;
    int          unstable_cnt = 0;
    txn_t        obs_q[$];
    logic [31:0] mem[logic [31:0]];

    // stimulus-owned reference model
    logic [TXN_W-1:0] exp_q[$];
    logic [31:0]      ref_mem[logic [31:0]];
    logic [31:0]      model_inst = 32'h0;
    logic [31:0]      model_data = 32'h0;

    sram_bus_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .core_stall      (core_stall),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .stallreq_bus    (stallreq_bus),
        .bus_req         (bus_req),
        .bus_wr          (bus_wr),
        .bus_wstrb       (bus_wstrb),
        .bus_addr        (bus_addr),
        .bus_wdata       (bus_wdata),
        .bus_addr_ok     (bus_addr_ok),
        .bus_data_ok     (bus_data_ok),
        .bus_rdata       (bus_rdata),
        .dbg_state       (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory contents ----------------
    function automatic logic [31:0] init_word(input logic [31:0] a);
        case (a)
            32'hBFC0_0000: return 32'h3C1D_8000;
            32'hBFC0_0004: return 32'h2408_0001;
            32'h8000_1000: return 32'h1234_5678;
            default:       return a ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] wen);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] slv_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // ---------------- behavioural bus slave + monitor ----------------
    always @(negedge clk) begin
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = $urandom;
        if (man_mode) begin
            bus_addr_ok = man_addr_ok;
            bus_data_ok = man_data_ok;
            bus_rdata   = man_rdata;
        end else if (rst) begin
            sl_phase = 0;
            sl_cnt   = 0;
            req_seen = 1'b0;
        end else if (sl_phase == 0) begin
            if (bus_req) begin
                req_cycles++;
                if (req_seen && (req_snap !== {bus_addr, bus_wr, bus_wstrb, bus_wdata}))
                    unstable_cnt++;
                if (!req_seen) begin
                    req_seen = 1'b1;
                    req_snap = {bus_addr, bus_wr, bus_wstrb, bus_wdata};
                end
                if (sl_cnt >= aw) begin
                    bus_addr_ok = 1'b1;
                    obs_q.push_back({bus_addr, bus_wr, bus_wstrb, bus_wdata});
                    req_seen = 1'b0;
                    sl_cnt   = 0;
                    if (sl_comb) begin
                        bus_data_ok = 1'b1;
                        if (bus_wr) mem[bus_addr] = merge(slv_rd(bus_addr), bus_wdata, bus_wstrb);
                        else        bus_rdata = slv_rd(bus_addr);
                    end else begin
                        sl_phase = 1;
                    end
                end else begin
                    sl_cnt++;
                    if (spurious) bus_data_ok = 1'b1;
                end
            end else if (spurious) begin
                bus_data_ok = 1'b1;
                bus_addr_ok = 1'b1;
            end
        end else begin
            if (sl_cnt >= dw) begin
                bus_data_ok = 1'b1;
                if (bus_wr) mem[bus_addr] = merge(slv_rd(bus_addr), bus_wdata, bus_wstrb);
                else        bus_rdata = slv_rd(bus_addr);
                sl_phase = 0;
                sl_cnt   = 0;
            end else begin
                sl_cnt++;
                if (spurious) bus_addr_ok = 1'b1;
            end
        end
    end

    // ---------------- driver: one core access with full scoreboard ----------------
    task automatic do_access(input string name, input bit ie, input logic [31:0] ia,
                             input bit de, input logic [3:0] wen, input logic [31:0] da,
                             input logic [31:0] wd, input int hold);
        logic [31:0] exp_i, exp_d;
        int nports, cost, exp_stall, exp_req, stall_cnt, obs0, req0, unst0, nobs;
        txn_t e, o;
        nports    = int'(ie) + int'(de);
        cost      = sl_comb ? (2 + aw) : (3 + aw + dw);
        exp_stall = nports * cost;
        exp_req   = nports * (aw + 1);
        exp_i     = ie ? ref_rd(ia) : model_inst;
        exp_d     = (de && wen == 4'b0000) ? ref_rd(da) : model_data;
        if (de) begin
            exp_q.push_back({da, |wen, wen, wd});
            if (wen != 4'b0000) ref_mem[da] = merge(ref_rd(da), wd, wen);
        end
        if (ie) exp_q.push_back({ia, 1'b0, 4'b0000, 32'h0});
        obs0  = obs_q.size();
        req0  = req_cycles;
        unst0 = unstable_cnt;

        @(negedge clk);
        inst_sram_en    = ie;
        inst_sram_addr  = ia;
        inst_sram_wen   = 4'($urandom);
        inst_sram_wdata = $urandom;
        data_sram_en    = de;
        data_sram_wen   = wen;
        data_sram_addr  = da;
        data_sram_wdata = wd;
        core_stall      = (hold > 0);
        #1;
        stall_cnt = 0;
        while (stallreq_bus === 1'b1 && stall_cnt < 200) begin
            stall_cnt++;
            @(negedge clk);
            #1;
        end
        n_vec++;
        if (stall_cnt >= 200) begin
            n_err++;
            $display("FAIL %s timeout: stall still high after %0d cycles, required %0d", name, stall_cnt, exp_stall);
        end else if (stall_cnt != exp_stall) begin
            n_err++;
            $display("FAIL %s stall_cycles: got %0d required %0d", name, stall_cnt, exp_stall);
        end
        n_vec++;
        if (inst_sram_rdata !== exp_i) begin
            n_err++;
            $display("FAIL %s inst_rdata: got %h required %h", name, inst_sram_rdata, exp_i);
        end
        n_vec++;
        if (data_sram_rdata !== exp_d) begin
            n_err++;
            $display("FAIL %s data_rdata: got %h required %h", name, data_sram_rdata, exp_d);
        end

        // core held by another source with the port enables still asserted
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (k == hold - 1) core_stall = 1'b0;
            #1;
            n_vec++;
            if (stallreq_bus !== 1'b0) begin
                n_err++;
                $display("FAIL %s hold_stall[%0d]: got %b required 0", name, k, stallreq_bus);
            end
        end

        @(negedge clk);
        inst_sram_en  = 1'b0;
        data_sram_en  = 1'b0;
        data_sram_wen = 4'b0000;
        core_stall    = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if (stallreq_bus !== 1'b0 || bus_req !== 1'b0) begin
            n_err++;
            $display("FAIL %s idle_after: stall=%b bus_req=%b required 0/0", name, stallreq_bus, bus_req);
        end

        nobs = obs_q.size() - obs0;
        n_vec++;
        if (nobs != exp_q.size()) begin
            n_err++;
            $display("FAIL %s txn_count: got %0d required %0d", name, nobs, exp_q.size());
        end else begin
            for (int i = 0; i < nobs; i++) begin
                e = exp_q[i];
                o = obs_q[obs0 + i];
                n_vec++;
                if (o.addr !== e.addr || o.wr !== e.wr || o.wstrb !== e.wstrb ||
                    (e.wr && o.wdata !== e.wdata)) begin
                    n_err++;
                    $display("FAIL %s txn[%0d]: got a=%h wr=%b s=%b d=%h required a=%h wr=%b s=%b d=%h",
                             name, i, o.addr, o.wr, o.wstrb, o.wdata, e.addr, e.wr, e.wstrb, e.wdata);
                end
            end
        end
        n_vec++;
        if (req_cycles - req0 != exp_req) begin
            n_err++;
            $display("FAIL %s bus_req_cycles: got %0d required %0d", name, req_cycles - req0, exp_req);
        end
        n_vec++;
        if (unstable_cnt != unst0) begin
            n_err++;
            $display("FAIL %s req_fields_stable: got %0d changes required 0", name, unstable_cnt - unst0);
        end
        exp_q.delete();
        model_inst = exp_i;
        model_data = exp_d;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        core_stall = 1'b0;
        inst_sram_en = 1'b1;
        inst_sram_wen = 4'b0000;
        inst_sram_addr = 32'hBFC0_0000;
        inst_sram_wdata = 32'h0;
        data_sram_en = 1'b1;
        data_sram_wen = 4'b1111;
        data_sram_addr = 32'h8000_0000;
        data_sram_wdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        n_vec++; if (stallreq_bus !== 1'b0) begin n_err++; $display("FAIL reset stallreq_bus: got %b required 0", stallreq_bus); end
        n_vec++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL reset bus_req: got %b required 0", bus_req); end
        n_vec++; if (bus_wr !== 1'b0) begin n_err++; $display("FAIL reset bus_wr: got %b required 0", bus_wr); end
        n_vec++; if (bus_wstrb !== 4'b0000) begin n_err++; $display("FAIL reset bus_wstrb: got %b required 0000", bus_wstrb); end
        n_vec++; if (bus_addr !== 32'h0) begin n_err++; $display("FAIL reset bus_addr: got %h required 0", bus_addr); end
        n_vec++; if (bus_wdata !== 32'h0) begin n_err++; $display("FAIL reset bus_wdata: got %h required 0", bus_wdata); end
        n_vec++; if (inst_sram_rdata !== 32'h0) begin n_err++; $display("FAIL reset inst_rdata: got %h required 0", inst_sram_rdata); end
        n_vec++; if (data_sram_rdata !== 32'h0) begin n_err++; $display("FAIL reset data_rdata: got %h required 0", data_sram_rdata); end
        rst = 1'b0;
        inst_sram_en = 1'b0;
        data_sram_en = 1'b0;
        data_sram_wen = 4'b0000;
    endtask

    task automatic test_fetch_only();
        aw = 0; dw = 0; sl_comb = 1'b0; spurious = 1'b0;
        do_access("fetch_only", 1'b1, 32'hBFC0_0000, 1'b0, 4'b0000, 32'h0, 32'h0, 0);
    endtask

    task automatic test_load_fetch();
        aw = 0; dw = 0; sl_comb = 1'b0; spurious = 1'b0;
        do_access("load_fetch", 1'b1, 32'hBFC0_0004, 1'b1, 4'b0000, 32'h8000_1000, 32'h0, 0);
    endtask

    task automatic test_store_byte();
        aw = 0; dw = 0; sl_comb = 1'b0; spurious = 1'b0;
        do_access("store_byte", 1'b0, 32'h0, 1'b1, 4'b0100, 32'h8000_0002, 32'h00AB_0000, 0);
    endtask

    task automatic test_addr_wait();
        aw = 4; dw = 1; sl_comb = 1'b0; spurious = 1'b1;
        do_access("addr_wait", 1'b0, 32'h0, 1'b1, 4'b0000, 32'h8000_1000, 32'h0, 0);
        spurious = 1'b0;
    endtask

    task automatic test_same_cycle_ok();
        aw = 0; dw = 0; sl_comb = 1'b1; spurious = 1'b0;
        do_access("same_cycle_ok", 1'b1, 32'hBFC0_0008, 1'b1, 4'b0000, 32'h8000_0020, 32'h0, 0);
        sl_comb = 1'b0;
    endtask

    task automatic test_hold();
        aw = 0; dw = 0; sl_comb = 1'b0; spurious = 1'b0;
        do_access("hold_store", 1'b1, 32'hBFC0_000C, 1'b1, 4'b1111, 32'h8000_0010, 32'hCAFE_F00D, 2);
        do_access("hold_readback", 1'b0, 32'h0, 1'b1, 4'b0000, 32'h8000_0010, 32'h0, 0);
    endtask

    task automatic test_reset_mid();
        man_mode = 1'b1;
        man_addr_ok = 1'b0;
        man_data_ok = 1'b0;
        man_rdata = 32'h0;
        @(negedge clk);
        data_sram_en   = 1'b1;
        data_sram_wen  = 4'b0000;
        data_sram_addr = 32'h8000_2000;
        @(negedge clk);
        man_addr_ok = 1'b1;
        #1;
        n_vec++; if (bus_req !== 1'b1) begin n_err++; $display("FAIL rst_mid req_issued: got %b required 1", bus_req); end
        @(negedge clk);
        man_addr_ok = 1'b0;
        rst = 1'b1;
        #1;
        n_vec++; if (stallreq_bus !== 1'b0) begin n_err++; $display("FAIL rst_mid stall_in_rst: got %b required 0", stallreq_bus); end
        @(negedge clk);
        rst = 1'b0;
        data_sram_en = 1'b0;
        man_data_ok = 1'b1;
        man_rdata = 32'hDEAD_BEEF;
        #1;
        n_vec++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL rst_mid bus_req: got %b required 0", bus_req); end
        n_vec++; if (stallreq_bus !== 1'b0) begin n_err++; $display("FAIL rst_mid stall: got %b required 0", stallreq_bus); end
        @(negedge clk);
        man_data_ok = 1'b0;
        #1;
        n_vec++; if (data_sram_rdata !== 32'h0) begin n_err++; $display("FAIL rst_mid late_data: got %h required 0", data_sram_rdata); end
        n_vec++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL rst_mid bus_req_after: got %b required 0", bus_req); end
        man_mode = 1'b0;
        model_inst = 32'h0;
        model_data = 32'h0;
    endtask

    task automatic test_random();
        bit          ie, de;
        logic [3:0]  wen, one;
        logic [31:0] ia, da;
        for (int it = 0; it < 12; it++) begin
            aw       = $urandom_range(0, 3);
            dw       = $urandom_range(0, 3);
            sl_comb  = 1'($urandom_range(0, 1));
            spurious = 1'($urandom_range(0, 1));
            ie       = 1'($urandom_range(0, 1));
            de       = 1'($urandom_range(0, 1));
            if (!ie && !de) de = 1'b1;
            one = 4'b0001;
            case ($urandom_range(0, 4))
                0, 1:    wen = 4'b0000;
                2:       wen = one << $urandom_range(0, 3);
                3:       wen = ($urandom_range(0, 1) != 0) ? 4'b0011 : 4'b1100;
                default: wen = 4'b1111;
            endcase
            ia = 32'hBFC0_0000 + 32'(4 * $urandom_range(0, 255));
            da = 32'h8000_0000 + 32'(4 * $urandom_range(0, 7));
            do_access("random", ie, ia, de, wen, da, $urandom, $urandom_range(0, 2));
        end
        spurious = 1'b0;
        sl_comb  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_load_fetch();
        test_store_byte();
        test_addr_wait();
        test_same_cycle_ok();
        test_hold();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
